// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search-window sequencer: default widths,
// the all-ones SAD ceiling and the sequencer state encoding.
package sad_pkg;

  localparam int SAD_W_DEFAULT = 32;
  localparam int IDX_W_DEFAULT = 8;

  localparam logic [SAD_W_DEFAULT-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sad_addr_gen.sv
// Row-major (row, column) walker: column advances on step and wraps into the
// next row; last flags the final coordinate of the window.
module sad_addr_gen #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/sad_search_ctrl.sv
// Search-window sequencer: issues every candidate displacement to the SAD
// engine and tracks the minimum. Optional early exit on a zero SAD is
// enabled by defining SAD_EARLY_EXIT_EN.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int SAD_W   = SAD_W_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT,
  parameter int MAX_OUT = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  output logic             Busy,
  output logic             CandValid,
  input  logic             CandReady,
  output logic [IDX_W-1:0] CandRow,
  output logic [IDX_W-1:0] CandColumn,
  input  logic             SADValid,
  input  logic [SAD_W-1:0] SADIn,
  output logic             Done,
  output logic [SAD_W-1:0] MinSAD,
  output logic [IDX_W-1:0] MinSADRow,
  output logic [IDX_W-1:0] MinSADColumn
);

  localparam logic [3:0]       OUT_LIMIT = 4'(MAX_OUT);
  localparam logic [SAD_W-1:0] MIN_INIT  = '1;

  state_t           state, state_next;
  logic             run, start_run, issue_step, accept;
  logic             issue_last, res_last, issue_done;
  logic             stop, stop_next;
  logic [3:0]       outstanding, out_next;
  logic [IDX_W-1:0] res_row, res_col;

  assign run        = (state == RUN);
  assign start_run  = (state == IDLE) && Start;
  assign CandValid  = run && !issue_done && !stop && (outstanding < OUT_LIMIT);
  assign issue_step = CandValid && CandReady;
  // Results with nothing outstanding, or outside RUN, are stale and dropped.
  assign accept     = run && SADValid && (outstanding != 4'd0);
  assign Busy       = run;
  assign Done       = (state == DONE);

  sad_addr_gen #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) u_issue_gen (
    .clk(Clk), .rst(Rst), .clear(start_run), .step(issue_step),
    .row(CandRow), .col(CandColumn), .last(issue_last)
  );

  sad_addr_gen #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) u_result_gen (
    .clk(Clk), .rst(Rst), .clear(start_run), .step(accept),
    .row(res_row), .col(res_col), .last(res_last)
  );

  always_comb begin
    out_next = outstanding;
    if (issue_step && !accept)
      out_next = outstanding + 4'd1;
    else if (!issue_step && accept)
      out_next = outstanding - 4'd1;
  end

`ifdef SAD_EARLY_EXIT_EN
  assign stop_next = stop || (accept && (SADIn == '0));

  always_ff @(posedge Clk) begin
    if (Rst || start_run)
      stop <= 1'b0;
    else if (run)
      stop <= stop_next;
  end
`else
  assign stop      = 1'b0;
  assign stop_next = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start) state_next = RUN;
      RUN: begin
        if (accept && res_last)
          state_next = DONE;
        else if (stop_next && (out_next == 4'd0))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || start_run) begin
      outstanding <= 4'd0;
      issue_done  <= 1'b0;
    end else if (run) begin
      outstanding <= out_next;
      if (issue_step && issue_last)
        issue_done <= 1'b1;
    end
  end

  // Strict compare keeps the earliest candidate among equal minima.
  always_ff @(posedge Clk) begin
    if (Rst || start_run) begin
      MinSAD       <= MIN_INIT;
      MinSADRow    <= '0;
      MinSADColumn <= '0;
    end else if (accept && !stop && (SADIn < MinSAD)) begin
      MinSAD       <= SADIn;
      MinSADRow    <= res_row;
      MinSADColumn <= res_col;
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench for sad_search_ctrl on a 4x4 window with MAX_OUT=2;
// a behavioural SAD engine returns table values in issue order.
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int ROWS = 4, COLS = 4, N = ROWS * COLS, MAX_OUT = 2;

  logic        Clk = 1'b0;
  logic        Rst, Start, CandReady, SADValid;
  logic [31:0] SADIn;
  logic        Busy, CandValid, Done;
  logic [7:0]  CandRow, CandColumn, MinSADRow, MinSADColumn;
  logic [31:0] MinSAD;

  always #5 Clk = ~Clk;

  sad_search_ctrl #(.ROWS(ROWS), .COLS(COLS), .SAD_W(32), .IDX_W(8), .MAX_OUT(MAX_OUT)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Busy(Busy), .CandValid(CandValid),
    .CandReady(CandReady), .CandRow(CandRow), .CandColumn(CandColumn),
    .SADValid(SADValid), .SADIn(SADIn), .Done(Done), .MinSAD(MinSAD),
    .MinSADRow(MinSADRow), .MinSADColumn(MinSADColumn)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_resp_cyc = 0, done_cyc = 0, n_resp = 0;
  logic [31:0] sad_tab [N];
  int eng_q [$];
  int exp_q [$];

  logic        s_done, s_busy, s_valid;
  logic [7:0]  s_row, s_col, s_mrow, s_mcol;
  logic [31:0] s_min;
  bit          x_xfer, r_zero;
  int          x_idx;

  // One clock of the engine model: sample at negedge, drive, wait for posedge.
  task automatic cycle(input bit rdy, input bit resp);
    @(negedge Clk);
    cyc++;
    s_done = Done; s_busy = Busy; s_valid = CandValid;
    s_row = CandRow; s_col = CandColumn;
    s_min = MinSAD; s_mrow = MinSADRow; s_mcol = MinSADColumn;
    CandReady = rdy;
    x_xfer = CandValid && rdy;
    x_idx = int'(CandRow) * COLS + int'(CandColumn);
    r_zero = 1'b0;
    if (resp && eng_q.size() > 0) begin
      SADValid = 1'b1;
      SADIn = sad_tab[eng_q.pop_front()];
      r_zero = (SADIn == 32'd0);
      last_resp_cyc = cyc;
      n_resp++;
    end else begin
      SADValid = 1'b0;
    end
    if (x_xfer) eng_q.push_back(x_idx);
    @(posedge Clk);
  endtask

  task automatic do_start();
    @(negedge Clk);
    Start = 1'b1; SADValid = 1'b0; CandReady = 1'b1;
    eng_q.delete();
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(i);
  endtask

  task automatic model_min(output logic [31:0] m, output logic [7:0] r, output logic [7:0] c);
    int idx = 0;
    m = '1;
    for (int i = 0; i < N; i++)
      if (sad_tab[i] < m) begin m = sad_tab[i]; idx = i; end
    r = 8'(idx / COLS);
    c = 8'(idx % COLS);
  endtask

  task automatic run_to_done(input int budget, output int bad, output bit got);
    bad = 0; got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle(1'b1, 1'b1);
      if (s_done) begin got = 1'b1; done_cyc = cyc; break; end
      if (x_xfer && (exp_q.size() == 0 || exp_q.pop_front() != x_idx)) bad++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Start = 1'b0; CandReady = 1'b0; SADValid = 1'b0; SADIn = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if ({Busy, CandValid, Done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got %b expected 000", {Busy, CandValid, Done});
    end
    n_checks++;
    if ({CandRow, CandColumn} !== 16'h0) begin
      n_fail++; $display("FAIL reset_cand got %h expected 0000", {CandRow, CandColumn});
    end
    n_checks++;
    if ({MinSAD, MinSADRow, MinSADColumn} !== {SAD_MAX, 16'h0}) begin
      n_fail++; $display("FAIL reset_min got %h/%0d/%0d expected ffffffff/0/0", MinSAD, MinSADRow, MinSADColumn);
    end
    Rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] em; logic [7:0] er, ec; int bad; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'(60 + i);
    sad_tab[0] = 50; sad_tab[1] = 20; sad_tab[2] = 30; sad_tab[3] = 40;
    model_min(em, er, ec);
    do_start(); fill_exp();
    cycle(1'b1, 1'b1);
    n_checks++;
    if ({s_busy, s_valid, x_xfer} !== 3'b111 || x_idx != exp_q.pop_front()) begin
      n_fail++; $display("FAIL basic_first got busy/valid/xfer %b idx %0d expected 111 idx 0", {s_busy, s_valid, x_xfer}, x_idx);
    end
    run_to_done(200, bad, got);
    n_checks++;
    if (!got || bad != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_walk got done=%0d bad=%0d left=%0d expected 1/0/0", got, bad, exp_q.size());
    end
    n_checks++;
    if (done_cyc != last_resp_cyc + 1 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_timing got cycle %0d busy %b expected %0d busy 0", done_cyc, s_busy, last_resp_cyc + 1);
    end
    n_checks++;
    if ({s_min, s_mrow, s_mcol} !== {em, er, ec}) begin
      n_fail++; $display("FAIL basic_min got %0d/%0d/%0d expected %0d/%0d/%0d", s_min, s_mrow, s_mcol, em, er, ec);
    end
    cycle(1'b0, 1'b0);
    n_checks++;
    if (s_done !== 1'b0 || s_min !== em) begin
      n_fail++; $display("FAIL basic_pulse_hold got done %b min %0d expected 0 %0d", s_done, s_min, em);
    end
  endtask

  task automatic test_tie();
    logic [31:0] em; logic [7:0] er, ec; int bad; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'd30;
    sad_tab[0] = 9; sad_tab[1] = 9; sad_tab[2] = 7; sad_tab[3] = 7;
    model_min(em, er, ec);
    do_start(); fill_exp();
    run_to_done(200, bad, got);
    n_checks++;
    if (!got || bad != 0) begin
      n_fail++; $display("FAIL tie_walk got done=%0d bad=%0d expected 1/0", got, bad);
    end
    n_checks++;
    if ({s_min, s_mrow, s_mcol} !== {em, er, ec}) begin
      n_fail++; $display("FAIL tie_min got %0d/%0d/%0d expected %0d/%0d/%0d", s_min, s_mrow, s_mcol, em, er, ec);
    end
  endtask

  task automatic test_throttle();
    logic [31:0] em; logic [7:0] er, ec; int bad, nx; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'(100 - i);
    model_min(em, er, ec);
    do_start(); fill_exp();
    nx = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      if (x_xfer) begin nx++; if (exp_q.pop_front() != x_idx) bad++; end
    end
    n_checks++;
    if (nx != MAX_OUT || s_valid !== 1'b0) begin
      n_fail++; $display("FAIL throttle_stop got issues %0d valid %b expected %0d valid 0", nx, s_valid, MAX_OUT);
    end
    cycle(1'b1, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL throttle_same_cycle got valid %b expected 0", s_valid);
    end
    nx = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      if (x_xfer) begin nx++; if (exp_q.pop_front() != x_idx) bad++; end
    end
    n_checks++;
    if (nx != 1) begin
      n_fail++; $display("FAIL throttle_one_more got issues %0d expected 1", nx);
    end
    run_to_done(200, got ? bad : bad, got);
    n_checks++;
    if (!got || bad != 0 || exp_q.size() != 0 || {s_min, s_mrow, s_mcol} !== {em, er, ec}) begin
      n_fail++; $display("FAIL throttle_finish got done=%0d bad=%0d min %0d/%0d/%0d expected 1/0 %0d/%0d/%0d",
                         got, bad, s_min, s_mrow, s_mcol, em, er, ec);
    end
  endtask

  task automatic test_stall();
    logic [31:0] em; logic [7:0] er, ec, hr, hc; int bad, bad2, moved; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'($urandom_range(1, 1000));
    model_min(em, er, ec);
    do_start(); fill_exp();
    bad = 0; moved = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      if (x_xfer && exp_q.pop_front() != x_idx) bad++;
    end
    cycle(1'b0, 1'b1);
    hr = s_row; hc = s_col;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1);
      if (x_xfer || s_valid !== 1'b1 || s_row !== hr || s_col !== hc) moved++;
    end
    n_checks++;
    if (moved != 0) begin
      n_fail++; $display("FAIL stall_hold got %0d unstable cycles expected 0 (held %0d,%0d)", moved, hr, hc);
    end
    run_to_done(200, bad2, got);
    n_checks++;
    if (!got || bad + bad2 != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL stall_walk got done=%0d bad=%0d left=%0d expected 1/0/0", got, bad + bad2, exp_q.size());
    end
    n_checks++;
    if ({s_min, s_mrow, s_mcol} !== {em, er, ec}) begin
      n_fail++; $display("FAIL stall_min got %0d/%0d/%0d expected %0d/%0d/%0d", s_min, s_mrow, s_mcol, em, er, ec);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] em; logic [7:0] er, ec; int bad; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'(500 - 3 * i);
    do_start(); fill_exp();
    n_resp = 0;
    for (int i = 0; i < 100 && n_resp < 5; i++) cycle(1'b1, 1'b1);
    @(negedge Clk);
    Rst = 1'b1; SADValid = 1'b0; CandReady = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    n_checks++;
    if ({Busy, CandValid, Done, CandRow, CandColumn} !== 19'h0 || MinSAD !== SAD_MAX) begin
      n_fail++; $display("FAIL midreset_state got busy %b valid %b cand %0d,%0d min %h expected 0 0 0,0 ffffffff",
                         Busy, CandValid, CandRow, CandColumn, MinSAD);
    end
    eng_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      SADValid = 1'b1; SADIn = 32'd1;
    end
    @(negedge Clk);
    SADValid = 1'b0;
    n_checks++;
    if (MinSAD !== SAD_MAX || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL stale_ignored got min %h busy %b done %b expected ffffffff 0 0", MinSAD, Busy, Done);
    end
    for (int i = 0; i < N; i++) sad_tab[i] = 32'(70 + (i % 5));
    sad_tab[11] = 32'd3;
    model_min(em, er, ec);
    do_start(); fill_exp();
    cycle(1'b1, 1'b1);
    n_checks++;
    if (!x_xfer || x_idx != exp_q.pop_front() || s_min !== SAD_MAX) begin
      n_fail++; $display("FAIL restart_origin got xfer %0d idx %0d min %h expected 1 0 ffffffff", x_xfer, x_idx, s_min);
    end
    run_to_done(200, bad, got);
    n_checks++;
    if (!got || bad != 0 || {s_min, s_mrow, s_mcol} !== {em, er, ec}) begin
      n_fail++; $display("FAIL restart_scan got done=%0d bad=%0d min %0d/%0d/%0d expected 1/0 %0d/%0d/%0d",
                         got, bad, s_min, s_mrow, s_mcol, em, er, ec);
    end
  endtask

`ifdef SAD_EARLY_EXIT_EN
  task automatic test_zero();
    int nx, late, zero_cyc; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'd20;
    sad_tab[0] = 40; sad_tab[1] = 30; sad_tab[2] = 0;
    do_start();
    nx = 0; late = 0; zero_cyc = -1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1);
      if (s_done) begin got = 1'b1; done_cyc = cyc; break; end
      if (x_xfer) begin nx++; if (zero_cyc >= 0) late++; end
      if (r_zero) zero_cyc = cyc;
    end
    n_checks++;
    if (!got || late != 0 || nx >= N || eng_q.size() != 0) begin
      n_fail++; $display("FAIL early_exit_issue got done=%0d late=%0d issued=%0d pending=%0d expected 1/0/<%0d/0",
                         got, late, nx, eng_q.size(), N);
    end
    n_checks++;
    if (done_cyc != last_resp_cyc + 1) begin
      n_fail++; $display("FAIL early_exit_done got cycle %0d expected %0d", done_cyc, last_resp_cyc + 1);
    end
    n_checks++;
    if ({s_min, s_mrow, s_mcol} !== {32'd0, 8'd0, 8'd2}) begin
      n_fail++; $display("FAIL early_exit_min got %0d/%0d/%0d expected 0/0/2", s_min, s_mrow, s_mcol);
    end
  endtask
`else
  task automatic test_zero();
    int bad; bit got;
    for (int i = 0; i < N; i++) sad_tab[i] = 32'd20;
    sad_tab[0] = 40; sad_tab[1] = 30; sad_tab[2] = 0;
    do_start(); fill_exp();
    run_to_done(200, bad, got);
    n_checks++;
    if (!got || bad != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL zero_full_walk got done=%0d bad=%0d left=%0d expected 1/0/0", got, bad, exp_q.size());
    end
    n_checks++;
    if ({s_min, s_mrow, s_mcol} !== {32'd0, 8'd0, 8'd2}) begin
      n_fail++; $display("FAIL zero_min got %0d/%0d/%0d expected 0/0/2", s_min, s_mrow, s_mcol);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_throttle();
    test_stall();
    test_reset_mid_scan();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
